// File: rtl/core_ex_muldiv.sv
// core_ex_muldiv: RV M-extension unit, shift-add multiply and restoring divide on operand magnitudes.
// Define CORE_MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module core_ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [2:0]      func3_in,
    input  logic [XLEN-1:0] opnum1_in,
    input  logic [XLEN-1:0] opnum2_in,
    input  logic [4:0]      rd_in,
    input  logic            flush_in,
    output logic            hold_flag_out,
    output logic            reg_we_out,
    output logic [4:0]      reg_write_addr_out,
    output logic [XLEN-1:0] reg_write_data_out
);
    localparam int CW = $clog2(XLEN) + 1;
`ifdef CORE_MULDIV_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`endif
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] func;
    logic [4:0] rd;
    logic neg1, neg2;
    logic [XLEN-1:0] opb;
    logic [2*XLEN-1:0] acc;
    logic s1, s2, in_neg1, in_neg2, div0, ovf;
    logic [XLEN-1:0] mag1, mag2, special, quo, rem, div_res;
    logic [XLEN+1:0] div_diff;
    logic [2*XLEN-1:0] div_next;
    always_comb begin
        s1 = func3_in inside {3'd1, 3'd2, 3'd4, 3'd6};
        s2 = func3_in inside {3'd1, 3'd4, 3'd6};
        in_neg1 = s1 & opnum1_in[XLEN-1];
        in_neg2 = s2 & opnum2_in[XLEN-1];
        mag1 = in_neg1 ? -opnum1_in : opnum1_in;
        mag2 = in_neg2 ? -opnum2_in : opnum2_in;
        div0 = opnum2_in == '0;
        ovf = !func3_in[0] && opnum1_in == {1'b1, {(XLEN-1){1'b0}}} && &opnum2_in;
        special = func3_in[1] ? (div0 ? opnum1_in : '0) : (div0 ? '1 : opnum1_in);
        // acc holds {partial remainder, dividend bits still to shift in / quotient bits}
        div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b0, opb};
        div_next = div_diff[XLEN+1] ? {acc[2*XLEN-2:0], 1'b0} : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        quo = div_next[XLEN-1:0];
        rem = div_next[2*XLEN-1:XLEN];
        div_res = func[1] ? (neg1 ? -rem : rem) : ((neg1 ^ neg2) ? -quo : quo);
        hold_flag_out = (state != IDLE && state != DONE) || (state == IDLE && start_in && !flush_in);
    end
`ifdef CORE_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0] fa, fb;
    logic signed [2*XLEN-1:0] fp;
    logic [XLEN-1:0] fast_res;
    always_comb begin
        fa = {s1 & opnum1_in[XLEN-1], opnum1_in};
        fb = {s2 & opnum2_in[XLEN-1], opnum2_in};
        fp = fa * fb;
        fast_res = func3_in == 3'd0 ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
    end
`else
    logic [XLEN:0] mul_sum;
    logic [2*XLEN-1:0] mul_next, prod;
    logic [XLEN-1:0] mul_res;
    always_comb begin
        // acc holds {partial product high half, remaining multiplier bits}
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        prod = (neg1 ^ neg2) ? -mul_next : mul_next;
        mul_res = func == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
`endif
    always_ff @(posedge clk) begin
        reg_we_out <= 1'b0;
        reg_write_addr_out <= '0;
        reg_write_data_out <= '0;
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            func <= '0;
            rd <= '0;
            neg1 <= 1'b0;
            neg2 <= 1'b0;
            opb <= '0;
            acc <= '0;
        end else if (flush_in) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    func <= func3_in;
                    rd <= rd_in;
                    neg1 <= in_neg1;
                    neg2 <= in_neg2;
                    opb <= mag2;
                    acc <= {{XLEN{1'b0}}, mag1};
                    cnt <= '0;
                    if (func3_in[2] && (div0 || ovf)) begin
                        state <= DONE;
                        reg_we_out <= 1'b1;
                        reg_write_addr_out <= rd_in;
                        reg_write_data_out <= special;
                    end else if (func3_in[2]) begin
                        state <= DIV;
                    end else begin
`ifdef CORE_MULDIV_FAST_MUL_EN
                        state <= DONE;
                        reg_we_out <= 1'b1;
                        reg_write_addr_out <= rd_in;
                        reg_write_data_out <= fast_res;
`else
                        state <= MUL;
`endif
                    end
                end
`ifndef CORE_MULDIV_FAST_MUL_EN
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state <= DONE;
                        reg_we_out <= 1'b1;
                        reg_write_addr_out <= rd;
                        reg_write_data_out <= mul_res;
                    end
                end
`endif
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state <= DONE;
                        reg_we_out <= 1'b1;
                        reg_write_addr_out <= rd;
                        reg_write_data_out <= div_res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_ex_muldiv.sv
// tb_core_ex_muldiv: directed and random checks of core_ex_muldiv against an arithmetic reference model.
module tb_core_ex_muldiv;
    localparam int X = 32;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0] func3 = '0;
    logic [X-1:0] op1 = '0, op2 = '0;
    logic [4:0] rd = '0;
    logic hold, we;
    logic [4:0] waddr;
    logic [X-1:0] wdata;
    int n_assert = 0, n_fail = 0, wb_count = 0;

    always #5 clk = ~clk;

    core_ex_muldiv #(.XLEN(X)) dut (
        .clk(clk), .rst(rst), .start_in(start), .func3_in(func3),
        .opnum1_in(op1), .opnum2_in(op2), .rd_in(rd), .flush_in(flush),
        .hold_flag_out(hold), .reg_we_out(we),
        .reg_write_addr_out(waddr), .reg_write_data_out(wdata)
    );

    always @(negedge clk) if (we) wb_count++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [X-1:0] model(input logic [2:0] f, input logic [X-1:0] a, input logic [X-1:0] b);
        logic [63:0] pa, pb, p, q, r;
        if (!f[2]) begin
            pa = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
            pb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
            p = pa * pb;
            return f == 3'd0 ? p[31:0] : p[63:32];
        end
        if (b == 0) return f[1] ? a : '1;
        if (!f[0]) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = {32'b0, a / b};
            r = {32'b0, a % b};
        end
        return f[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [X-1:0] a, input logic [X-1:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef CORE_MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return X + 1;
    endfunction

    function automatic logic [X-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [X-1:0] a, input logic [X-1:0] b,
                          input logic [4:0] r, input logic [X-1:0] exp);
        int edges, wb0;
        @(negedge clk);
        func3 = f; op1 = a; op2 = b; rd = r; start = 1'b1;
        #1 check("hold_idle_req", hold, 1);
        wb0 = wb_count;
        @(posedge clk);
        edges = 1;
        #1;
        while (!we && edges < 200) begin
            check("hold_busy", hold, 1);
            @(negedge clk) start = 1'b0;
            @(posedge clk);
            edges++;
            #1;
        end
        check("latency", edges, lat_of(f, a, b));
        check("we_done", we, 1);
        check("data", wdata, exp);
        check("addr", waddr, r);
        check("hold_done", hold, 0);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1 check("we_pulse_end", we, 0);
        check("data_cleared", wdata, 0);
        check("wb_once", wb_count - wb0, 1);
    endtask

    initial begin
        int wb0, edges;
        logic [2:0] f;
        logic [X-1:0] a, b;
        repeat (3) @(posedge clk);
        #1 check("rst_we", we, 0);
        check("rst_data", wdata, 0);
        check("rst_addr", waddr, 0);
        check("rst_hold", hold, 0);
        @(negedge clk) rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF);
        run_op(3'd4, -32'sd7, 32'd2, 5'd4, 32'hFFFF_FFFD);
        run_op(3'd6, -32'sd7, 32'd2, 5'd5, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 5'd6, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 5'd7, 32'd2);
        run_op(3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd5, 32'd0, 5'd10, 32'd5);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0);

        // flush a DIVU in flight: no write-back, next request runs normally
        wb0 = wb_count;
        @(negedge clk);
        func3 = 3'd5; op1 = 32'd1000; op2 = 32'd3; rd = 5'd13; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 check("flush_we", we, 0);
        check("flush_hold", hold, 0);
        check("flush_data", wdata, 0);
        @(negedge clk) flush = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("flush_no_wb", wb_count - wb0, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd14, 32'd14);

        // flush beats a simultaneous start in IDLE
        wb0 = wb_count;
        @(negedge clk);
        func3 = 3'd4; op1 = 32'd50; op2 = 32'd5; start = 1'b1; flush = 1'b1;
        #1 check("flush_start_hold", hold, 0);
        @(posedge clk);
        @(negedge clk) begin start = 1'b0; flush = 1'b0; end
        #1 check("flush_start_idle", hold, 0);
        repeat (40) @(posedge clk);
        #1 check("flush_start_no_wb", wb_count - wb0, 0);

        // reset during a multiply discards it
        wb0 = wb_count;
        @(negedge clk);
        func3 = 3'd0; op1 = 32'd123; op2 = 32'd456; rd = 5'd15; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("midrst_we", we, 0);
        check("midrst_data", wdata, 0);
        check("midrst_addr", waddr, 0);
        check("midrst_hold", hold, 0);
        @(negedge clk) rst = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("midrst_no_wb", wb_count - wb0, 0);

        // start held high through a DIV is ignored while busy
        wb0 = wb_count;
        @(negedge clk);
        func3 = 3'd4; op1 = -32'sd1000; op2 = 32'd7; rd = 5'd16; start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        while (!we && edges < 200) begin
            @(negedge clk) func3 = 3'($urandom_range(0, 7));
            @(posedge clk);
            edges++;
            #1;
        end
        check("held_latency", edges, X + 1);
        check("held_data", wdata, model(3'd4, -32'sd1000, 32'd7));
        check("held_addr", waddr, 16);
        check("held_hold_done", hold, 0);
        @(negedge clk) start = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("held_one_wb", wb_count - wb0, 1);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, 5'($urandom_range(0, 31)), model(f, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
